alu_pipe: RTL and testbench

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both ends and an internal multiply-accumulate register. It replaces the fixed 4-bit free-running registered ALU in datapaths that need back-pressure, wider operands, MAC and status flags. It sits between an operand producer (stream source) and a result consumer (stream sink).

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 71 +++++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose : shared opcode encoding for the pipelined ALU.
// Contents: OP_W (opcode width) and the eight opcode values OP_ADD..OP_CLR.
//           Every value of the 3-bit opcode is used.
package alu_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_MAC = 3'd6;
  localparam logic [OP_W-1:0] OP_CLR = 3'd7;
endpackage

// File: rtl/alu_core.sv
// Purpose : combinational ALU datapath, with no state of its own.
// Ports   : a, b     - unsigned operands (W bits)
//           op       - opcode (see alu_pkg)
//           acc      - current accumulator value (2W bits)
//           res      - result (2W bits)
//           ovf      - carry / borrow / accumulator-wrap flag
//           acc_next - accumulator value after this op
//           acc_we   - high for MAC and CLR, the only ops that write the accumulator
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  input  logic [2*W-1:0]  acc,
  output logic [2*W-1:0]  res,
  output logic            ovf,
  output logic [2*W-1:0]  acc_next,
  output logic            acc_we
);

  logic [2*W-1:0] a_x;
  logic [2*W-1:0] b_x;
  logic [2*W-1:0] prod;
  logic [W:0]     sum;
  logic [2*W:0]   mac_sum;

  assign a_x     = {{W{1'b0}}, a};
  assign b_x     = {{W{1'b0}}, b};
  assign prod    = a_x * b_x;
  assign sum     = {1'b0, a} + {1'b0, b};
  // The extra top bit of the accumulator sum is the wrap indication.
  assign mac_sum = {1'b0, acc} + {1'b0, prod};

  always_comb begin
    res      = '0;
    ovf      = 1'b0;
    acc_next = acc;
    acc_we   = 1'b0;
    case (op)
      OP_ADD: begin
        res = {{(W-1){1'b0}}, sum};
        ovf = sum[W];
      end
      OP_SUB: begin
        // A 2W-bit subtraction of the zero-extended operands yields the
        // sign-extended two's complement difference.
        res = a_x - b_x;
        ovf = (a < b);
      end
      OP_MUL: res = prod;
      OP_OR:  res = a_x | b_x;
      OP_AND: res = a_x & b_x;
      OP_XOR: res = a_x ^ b_x;
      OP_MAC: begin
        res      = mac_sum[2*W-1:0];
        ovf      = mac_sum[2*W];
        acc_next = mac_sum[2*W-1:0];
        acc_we   = 1'b1;
      end
      default: begin // OP_CLR
        res      = '0;
        acc_next = '0;
        acc_we   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Purpose : two-stage pipelined ALU with a valid/ready handshake on both ends
//           and an internal multiply-accumulate register.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous reset, active low
//           in_valid  / in_ready  - operand beat handshake (a, b, op)
//           out_valid / out_ready - result beat handshake (out, zero, ovf)
//           out       - 2W-bit result
//           zero      - high when out == 0
//           ovf       - carry / borrow / accumulator-wrap flag
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out,
  output logic            zero,
  output logic            ovf
);

  logic [W-1:0]    a_p1_q, a_p1_d;
  logic [W-1:0]    b_p1_q, b_p1_d;
  logic [OP_W-1:0] op_p1_q, op_p1_d;
  logic            vld_p1_q, vld_p1_d;
  logic [2*W-1:0]  out_p2_q, out_p2_d;
  logic            zero_p2_q, zero_p2_d;
  logic            ovf_p2_q, ovf_p2_d;
  logic            vld_p2_q, vld_p2_d;
  logic [2*W-1:0]  acc_q, acc_d;

  logic            s2_ready;
  logic            accept;
  logic            adv;
  logic [2*W-1:0]  res_p1;
  logic            ovf_p1;
  logic [2*W-1:0]  acc_nxt_p1;
  logic            acc_we_p1;

  // Ready runs backwards combinationally so a full stage can drain and
  // refill in the same cycle; nothing here depends on in_valid.
  assign s2_ready = !vld_p2_q | out_ready;
  assign in_ready = !vld_p1_q | s2_ready;
  assign accept   = in_valid & in_ready;
  assign adv      = vld_p1_q & s2_ready;

  alu_core #(.W(W)) u_core (
    .a        (a_p1_q),
    .b        (b_p1_q),
    .op       (op_p1_q),
    .acc      (acc_q),
    .res      (res_p1),
    .ovf      (ovf_p1),
    .acc_next (acc_nxt_p1),
    .acc_we   (acc_we_p1)
  );

  always_comb begin
    // Stage 1: operand capture
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    op_p1_d  = op_p1_q;
    vld_p1_d = vld_p1_q;
    if (accept) begin
      a_p1_d   = a;
      b_p1_d   = b;
      op_p1_d  = op;
      vld_p1_d = 1'b1;
    end else if (adv) begin
      vld_p1_d = 1'b0;
    end

    // Stage 2: registered result, flags and accumulator commit
    out_p2_d  = out_p2_q;
    zero_p2_d = zero_p2_q;
    ovf_p2_d  = ovf_p2_q;
    vld_p2_d  = vld_p2_q;
    acc_d     = acc_q;
    if (adv) begin
      out_p2_d  = res_p1;
      zero_p2_d = (res_p1 == '0);
      ovf_p2_d  = ovf_p1;
      vld_p2_d  = 1'b1;
      // The accumulator moves only with the beat, so a stalled MAC is applied once.
      if (acc_we_p1) acc_d = acc_nxt_p1;
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      op_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      out_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      acc_q     <= '0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      op_p1_q   <= op_p1_d;
      vld_p1_q  <= vld_p1_d;
      out_p2_q  <= out_p2_d;
      zero_p2_q <= zero_p2_d;
      ovf_p2_q  <= ovf_p2_d;
      vld_p2_q  <= vld_p2_d;
      acc_q     <= acc_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out       = out_p2_q;
  assign zero      = zero_p2_q;
  assign ovf       = ovf_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose : bench for alu_pipe (W=4). Expected {out, zero, ovf} values are
//           queued when a beat is accepted and compared when the result
//           leaves the pipeline.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W     = 4;
  localparam int EW    = 2*W + 2;
  localparam int MAXW  = (1 << W) - 1;
  localparam int MASK2 = (1 << (2*W)) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic [OP_W-1:0] op = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  out;
  logic            zero;
  logic            ovf;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  logic [EW-1:0] sb[$];

  alu_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, written on plain integers.
  function automatic logic [EW-1:0] model(input logic [2:0] o, input int x, input int y);
    int r;
    bit f;
    r = 0;
    f = 1'b0;
    case (o)
      OP_ADD: begin r = x + y; f = (r > MAXW); end
      OP_SUB: begin r = (x - y) & MASK2; f = (x < y); end
      OP_MUL: r = x * y;
      OP_OR:  r = x | y;
      OP_AND: r = x & y;
      OP_XOR: r = x ^ y;
      OP_MAC: begin r = m_acc + x * y; f = (r > MASK2); r = r & MASK2; m_acc = r; end
      default: begin r = 0; m_acc = 0; end
    endcase
    return {r[2*W-1:0], (r == 0), f};
  endfunction

  // Called right after a falling edge; returns at a later falling edge.
  task automatic send(input logic [2:0] o, input int x, input int y,
                      input bit fix, input logic [2*W-1:0] eo, input logic eovf);
    logic [EW-1:0] e;
    int n;
    in_valid = 1'b1;
    op = o;
    a  = x[W-1:0];
    b  = y[W-1:0];
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    e = model(o, x, y);
    if (fix) e = {eo, (eo == '0), eovf};
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: samples between edges, after the stimulus has settled.
  logic [EW-1:0] prev_o;
  bit            prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("stall_hold", {54'd0, out, zero, ovf}, {54'd0, prev_o});
      prev_stall = out_valid && !out_ready;
      prev_o     = {out, zero, ovf};
      if (out_valid && out_ready) begin
        chk("have_expected", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", {54'd0, out, zero, ovf}, {54'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out", {56'd0, out}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic ops
    send(OP_ADD, 9, 8, 1, 8'h11, 1'b1);
    send(OP_SUB, 3, 5, 1, 8'hFE, 1'b1);
    send(OP_MUL, 15, 15, 1, 8'hE1, 1'b0);
    send(OP_AND, 5, 10, 1, 8'h00, 1'b0);
    send(OP_OR, 5, 10, 0, '0, 1'b0);
    send(OP_SUB, 7, 7, 0, '0, 1'b0);
    drain();

    // MAC sequence
    send(OP_CLR, 0, 0, 1, 8'h00, 1'b0);
    send(OP_MAC, 15, 15, 1, 8'hE1, 1'b0);
    send(OP_MAC, 15, 15, 1, 8'hC2, 1'b1);
    send(OP_ADD, 1, 1, 1, 8'h02, 1'b0);
    send(OP_MAC, 1, 1, 1, 8'hC3, 1'b0);
    drain();

    // Back-pressure: 4 ADD beats with the sink stalled for 3 cycles
    fork
      begin
        for (int i = 0; i < 4; i++) send(OP_ADD, i + 3, 2 * i + 1, 0, '0, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Full throughput: 8 XOR beats, source and sink always ready
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(OP_XOR, i, (3 * i + 1) & MAXW, 0, '0, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (8) begin
          #2;
          if (out_valid) cnt++;
          @(negedge clk);
        end
        chk("throughput", 64'(cnt), 64'd8);
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(OP_MAC, 15, 15, 0, '0, 1'b0);
    send(OP_ADD, 1, 2, 0, '0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out", {56'd0, out}, 64'd0);
    chk("arst_flags", {62'd0, zero, ovf}, 64'd0);
    sb.delete();
    m_acc = 0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) @(negedge clk);
    send(OP_MAC, 2, 3, 1, 8'h06, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
